serial_word_framer: RTL and testbench

// - Upstream feeder for the word FIFO. Deframes a one-wire serial stream into WORDSIZE-bit words.
// - Frame format: start bit (0), WORDSIZE data bits MSB first, optional even-parity bit, stop bit (1).
// - Good words are offered on a valid/ready push port wired to the FIFO write side.
// - FIFO "full" maps to word_ready=0. Framing, parity and overrun errors are sticky status flags.

---
 rtl/framer_pkg.sv | 19 +
 rtl/word_hold_reg.sv | 35 +++
 rtl/serial_word_framer.sv | 99 +++++++++
 tb/tb_serial_word_framer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/framer_pkg.sv
// Shared types and helpers for the serial word deframer.
package framer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
  } framer_state_t;

  localparam logic FRAME_IDLE_LVL = 1'b1;

  // Returns 1 when v holds an odd number of ones. Callers zero-extend narrower vectors.
  function automatic logic even_par(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/word_hold_reg.sv
// One-entry valid/ready holding register feeding the word FIFO write port.
module word_hold_reg #(
  parameter int W = 4
) (
  input  logic         myclock,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         drop
);

  logic xfer;
  logic accept;

  assign xfer   = valid & ready;
  // A held word may be replaced only on the edge it leaves.
  assign accept = load & (~valid | ready);
  assign drop   = load & valid & ~ready;

  always_ff @(posedge myclock or negedge resetn) begin
    if (!resetn) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (accept) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (xfer) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_word_framer.sv
// Deframes a one-wire start/data/parity/stop stream into words for the FIFO write side.
module serial_word_framer
  import framer_pkg::*;
#(
  parameter int WORDSIZE  = 4,
  parameter int PARITY_EN = 1,
  parameter int CNTW      = $clog2(WORDSIZE + 1)
) (
  input  logic                myclock,
  input  logic                resetn,
  input  logic                sdata_in,
  input  logic                sen,
  output logic [WORDSIZE-1:0] word_out,
  output logic                word_valid,
  input  logic                word_ready,
  output logic                busy,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun,
  input  logic                err_clr
);

  framer_state_t       state;
  logic [WORDSIZE-1:0] shreg;
  logic [CNTW-1:0]     cnt;
  logic                perr;

  logic stop_smp;
  logic stop_ok;
  logic good_evt;
  logic perr_evt;
  logic ferr_evt;
  logic drop_evt;

  assign stop_smp = sen & (state == STOP);
  assign stop_ok  = (sdata_in == FRAME_IDLE_LVL);
  assign good_evt = stop_smp & stop_ok & ~perr;
  assign perr_evt = stop_smp & stop_ok & perr;
  assign ferr_evt = stop_smp & ~stop_ok;
  assign busy     = (state != IDLE);

  always_ff @(posedge myclock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      perr  <= 1'b0;
    end else if (sen) begin
      unique case (state)
        IDLE: begin
          if (sdata_in != FRAME_IDLE_LVL) begin
            state <= DATA;
            cnt   <= '0;
            perr  <= 1'b0;
          end
        end
        DATA: begin
          shreg <= {shreg[WORDSIZE-2:0], sdata_in};
          cnt   <= cnt + 1'b1;
          if (cnt == CNTW'(WORDSIZE - 1))
            state <= (PARITY_EN != 0) ? PARITY : STOP;
        end
        PARITY: begin
          perr  <= even_par(32'({shreg, sdata_in}));
          state <= STOP;
        end
        STOP:  state <= stop_ok ? IDLE : BREAK;
        // A low line here is the tail of a broken frame, never a new start bit.
        BREAK: if (sdata_in == FRAME_IDLE_LVL) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  word_hold_reg #(.W(WORDSIZE)) u_hold (
    .myclock   (myclock),
    .resetn    (resetn),
    .load      (good_evt),
    .load_data (shreg),
    .ready     (word_ready),
    .data      (word_out),
    .valid     (word_valid),
    .drop      (drop_evt)
  );

  // A fresh error on the clearing edge takes priority over err_clr.
  always_ff @(posedge myclock or negedge resetn) begin
    if (!resetn) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= (parity_err & ~err_clr) | perr_evt;
      frame_err  <= (frame_err  & ~err_clr) | ferr_evt;
      overrun    <= (overrun    & ~err_clr) | drop_evt;
    end
  end

endmodule

// File: tb/tb_serial_word_framer.sv
// Directed bench for serial_word_framer with a word scoreboard and separate output monitor.
module tb_serial_word_framer;

  logic       myclock = 1'b0;
  logic       resetn;
  logic       sdata_in;
  logic       sen;
  logic [3:0] word_out;
  logic       word_valid;
  logic       word_ready;
  logic       busy;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  always #5 myclock = ~myclock;

  serial_word_framer #(.WORDSIZE(4), .PARITY_EN(1)) dut (
    .myclock    (myclock),
    .resetn     (resetn),
    .sdata_in   (sdata_in),
    .sen        (sen),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // One enabled edge; with gap, an unsampled edge carrying the opposite level comes first.
  task automatic line_bit(input logic b, input bit gap);
    if (gap) begin
      sen = 1'b0; sdata_in = ~b;
      @(posedge myclock); #1;
    end
    sen = 1'b1; sdata_in = b;
    @(posedge myclock); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) line_bit(1'b1, 1'b0);
  endtask

  task automatic drain();
    word_ready = 1'b1;
    idle(1);
    word_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] w, input bit bad_par, input bit stop,
                            input bit rdy_stop, input bit gap);
    line_bit(1'b0, gap);
    for (int i = 3; i >= 0; i--) line_bit(w[i], gap);
    line_bit((^w) ^ bad_par, gap);
    if (rdy_stop) word_ready = 1'b1;
    line_bit(stop, gap);
    if (rdy_stop) word_ready = 1'b0;
    sdata_in = 1'b1;
  endtask

  // Monitor: a word is newly presented when valid rises or stays high across a transfer.
  initial begin
    logic       pv;
    logic       pr;
    logic [3:0] last;
    pv = 1'b0; pr = 1'b0; last = '0;
    forever begin
      @(negedge myclock);
      if (resetn === 1'b1) begin
        if (word_valid && (!pv || pr)) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected got %0h want none", word_out);
          end else begin
            check("sb_word", 32'(word_out), 32'(exp_q.pop_front()));
          end
          last = word_out;
        end else if (word_valid && pv && !pr) begin
          check("sb_stable", 32'(word_out), 32'(last));
        end
      end
      pv = word_valid;
      pr = word_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; sdata_in = 1'b1; sen = 1'b0; word_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge myclock);
    #1;
    check("rst_valid", 32'(word_valid), 0);
    check("rst_word",  32'(word_out), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_flags", 32'({parity_err, frame_err, overrun}), 0);
    resetn = 1'b1;
    idle(2);

    // Basic 0xA, ready low
    exp_q.push_back(4'hA);
    send_frame(4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
    check("basic_valid", 32'(word_valid), 1);
    check("basic_flags", 32'({parity_err, frame_err, overrun}), 0);
    check("basic_busy",  32'(busy), 0);
    drain();
    check("basic_drain", 32'(word_valid), 0);

    // Bad parity
    send_frame(4'hA, 1'b1, 1'b1, 1'b0, 1'b0);
    check("par_err",   32'(parity_err), 1);
    check("par_valid", 32'(word_valid), 0);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    check("par_clr",   32'(parity_err), 0);

    // Framing error, line held low, then a good frame
    exp_q.push_back(4'h6);
    send_frame(4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("frm_err",  32'(frame_err), 1);
    check("frm_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) line_bit(1'b0, 1'b0);
    check("frm_low_valid", 32'(word_valid), 0);
    check("frm_low_busy",  32'(busy), 1);
    idle(1);
    check("frm_idle_busy", 32'(busy), 0);
    send_frame(4'h6, 1'b0, 1'b1, 1'b0, 1'b0);
    check("frm_next_valid", 32'(word_valid), 1);
    drain();
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    check("frm_clr", 32'(frame_err), 0);

    // Overrun
    exp_q.push_back(4'h3);
    send_frame(4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(4'h5, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovr_flag",  32'(overrun), 1);
    check("ovr_valid", 32'(word_valid), 1);
    check("ovr_word",  32'(word_out), 32'h3);
    drain();
    check("ovr_drain", 32'(word_valid), 0);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 0);

    // Handshake: ready on the stop edge of 0x9 while 0xC is held
    exp_q.push_back(4'hC);
    send_frame(4'hC, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    exp_q.push_back(4'h9);
    send_frame(4'h9, 1'b0, 1'b1, 1'b1, 1'b0);
    check("hs_valid", 32'(word_valid), 1);
    check("hs_word",  32'(word_out), 32'h9);
    check("hs_ovr",   32'(overrun), 0);
    drain();

    // Enable gating across frame 0xE
    exp_q.push_back(4'hE);
    send_frame(4'hE, 1'b0, 1'b1, 1'b0, 1'b1);
    check("gate_valid", 32'(word_valid), 1);
    check("gate_flags", 32'({parity_err, frame_err, overrun}), 0);
    drain();

    // Mid-frame reset with a held word and a flag set
    exp_q.push_back(4'h1);
    send_frame(4'h1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_rst_state", 32'({word_valid, parity_err}), 32'h3);
    line_bit(1'b0, 1'b0);
    line_bit(1'b0, 1'b0);
    line_bit(1'b1, 1'b0);
    check("pre_rst_busy", 32'(busy), 1);
    resetn = 1'b0;
    #1;
    check("mrst_valid", 32'(word_valid), 0);
    check("mrst_word",  32'(word_out), 0);
    check("mrst_busy",  32'(busy), 0);
    check("mrst_flags", 32'({parity_err, frame_err, overrun}), 0);
    @(posedge myclock); #1;
    resetn = 1'b1;
    idle(1);
    exp_q.push_back(4'h6);
    send_frame(4'h6, 1'b0, 1'b1, 1'b0, 1'b0);
    check("post_rst_valid", 32'(word_valid), 1);
    check("post_rst_flags", 32'({parity_err, frame_err, overrun}), 0);
    drain();
    idle(2);

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
